// File: rtl/mul_accumulate_writeback.sv
// mul_accumulate_writeback
// Sequences the register-file writeback of multiply / multiply-accumulate
// results: waits for the multiplier product, adds the accumulator, writes one
// or two words with a ready handshake, and reports N/Z flags on completion.
// Build option MUL_LONG_OPS_EN: when defined, the 64-bit long ops
// (UMULL/UMLAL/SMULL/SMLAL) and the high-word write path are built; when
// undefined, ops 2-5 abort as illegal and only the 32-bit path exists.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_PROD | waiting for prod_valid, timeout down-counter running
// WR_LO     | writing short result or low word of long result
// WR_HI     | writing high word of long result (long build only)
// DONE      | one-cycle completion pulse, err marks an aborted op
module mul_accumulate_writeback #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        set_flags,
  input  logic [3:0]  rd_lo_idx,
  input  logic [3:0]  rd_hi_idx,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  input  logic        prod_valid,
  input  logic [31:0] prod_lo,
  input  logic [31:0] prod_hi,
  input  logic        wr_ready,
  output logic        busy,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic        flag_we,
  output logic        flag_n,
  output logic        flag_z,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_MLA = 3'd1;
`ifdef MUL_LONG_OPS_EN
  localparam logic [2:0] OP_UMLAL = 3'd3;
  localparam logic [2:0] OP_SMLAL = 3'd5;
  localparam int RES_W = 64;
`else
  localparam int RES_W = 32;
`endif
  // WAIT_PROD lasts TIMEOUT_CYCLES cycles: counter runs from N-1 down to 0
  localparam logic [3:0] TO_LOAD = 4'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PROD,
    WR_LO,
`ifdef MUL_LONG_OPS_EN
    WR_HI,
`endif
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             sf_q, sf_d;
  logic [3:0]       lo_idx_q, lo_idx_d;
  logic [31:0]      acc_lo_q, acc_lo_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
`ifdef MUL_LONG_OPS_EN
  logic [3:0]       hi_idx_q, hi_idx_d;
  logic [31:0]      acc_hi_q, acc_hi_d;

  function automatic logic op_legal(input logic [2:0] o);
    return o <= OP_SMLAL;
  endfunction

  function automatic logic is_long(input logic [2:0] o);
    return (o > OP_MLA) && (o <= OP_SMLAL);
  endfunction
`else
  logic unused_long_inputs;
  assign unused_long_inputs = ^{rd_hi_idx, acc_hi, prod_hi};

  function automatic logic op_legal(input logic [2:0] o);
    return o <= OP_MLA;
  endfunction
`endif

  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

  // Next-state, datapath capture and output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sf_d     = sf_q;
    lo_idx_d = lo_idx_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
`ifdef MUL_LONG_OPS_EN
    hi_idx_d = hi_idx_q;
    acc_hi_d = acc_hi_q;
`endif
    busy     = 1'b1;
    wr_en    = 1'b0;
    wr_idx   = 4'd0;
    wr_data  = 32'd0;
    flag_we  = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          op_d     = op;
          sf_d     = set_flags;
          lo_idx_d = rd_lo_idx;
          acc_lo_d = acc_lo;
          cnt_d    = TO_LOAD;
`ifdef MUL_LONG_OPS_EN
          hi_idx_d = rd_hi_idx;
          acc_hi_d = acc_hi;
`endif
          err_d    = !op_legal(op);
          state_d  = op_legal(op) ? WAIT_PROD : DONE;
        end
      end

      WAIT_PROD: begin
        if (prod_valid) begin
`ifdef MUL_LONG_OPS_EN
          if (is_long(op_q)) begin
            res_d = {prod_hi, prod_lo} +
                    (((op_q == OP_UMLAL) || (op_q == OP_SMLAL)) ? {acc_hi_q, acc_lo_q} : 64'd0);
            // same destination for both halves: only the high word lands
            state_d = (lo_idx_q == hi_idx_q) ? WR_HI : WR_LO;
          end else begin
            res_d   = {32'd0, prod_lo + ((op_q == OP_MLA) ? acc_lo_q : 32'd0)};
            state_d = WR_LO;
          end
`else
          res_d   = prod_lo + ((op_q == OP_MLA) ? acc_lo_q : 32'd0);
          state_d = WR_LO;
`endif
        end else if (cnt_q == 4'd0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WR_LO: begin
        wr_en   = 1'b1;
        wr_idx  = lo_idx_q;
        wr_data = res_q[31:0];
        if (wr_ready) begin
`ifdef MUL_LONG_OPS_EN
          if (is_long(op_q)) begin
            state_d = WR_HI;
          end else begin
            flag_n_d = res_q[31];
            flag_z_d = (res_q[31:0] == 32'd0);
            state_d  = DONE;
          end
`else
          flag_n_d = res_q[31];
          flag_z_d = (res_q[31:0] == 32'd0);
          state_d  = DONE;
`endif
        end
      end

`ifdef MUL_LONG_OPS_EN
      WR_HI: begin
        wr_en   = 1'b1;
        wr_idx  = hi_idx_q;
        wr_data = res_q[63:32];
        if (wr_ready) begin
          flag_n_d = res_q[63];
          flag_z_d = (res_q == 64'd0);
          state_d  = DONE;
        end
      end
`endif

      DONE: begin
        done    = 1'b1;
        err     = err_q;
        flag_we = sf_q & ~err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      sf_q     <= 1'b0;
      lo_idx_q <= 4'd0;
      acc_lo_q <= 32'd0;
      cnt_q    <= 4'd0;
      res_q    <= '0;
      err_q    <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
`ifdef MUL_LONG_OPS_EN
      hi_idx_q <= 4'd0;
      acc_hi_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sf_q     <= sf_d;
      lo_idx_q <= lo_idx_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
`ifdef MUL_LONG_OPS_EN
      hi_idx_q <= hi_idx_d;
      acc_hi_q <= acc_hi_d;
`endif
    end
  end

endmodule

// File: doc/mul_accumulate_writeback.md
MUL_ACCUMULATE_WRITEBACK -- requirements
Module: mul_accumulate_writeback

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8, max cycles in WAIT_PROD before abort (range 1..15).
REQ-002 SHALL have ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle op request, sampled only in IDLE.
- op  input  3  0=MUL, 1=MLA, 2=UMULL, 3=UMLAL, 4=SMULL, 5=SMLAL, 6-7 illegal.
- set_flags  input  1  S bit.
- rd_lo_idx  input  4  destination Rd (short) or RdLo (long).
- rd_hi_idx  input  4  RdHi (long only).
- acc_lo  input  32  accumulate operand Rn (short) or RdLo (long).
- acc_hi  input  32  accumulate high word RdHi (long).
- prod_valid  input  1  product from multiplier valid this cycle.
- prod_lo  input  32  product bits 31:0.
- prod_hi  input  32  product bits 63:32, already sign/zero-extended upstream.
- wr_ready  input  1  register file accepts write.
- busy  output  1  high in every state except IDLE.
- wr_en  output  1  register write request.
- wr_idx  output  4  register index.
- wr_data  output  32  register data.
- flag_we  output  1  one-cycle N/Z update strobe.
- flag_n  output  1  negative flag value.
- flag_z  output  1  zero flag value.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: operation aborted.

Function
REQ-003 SHALL implement states IDLE, WAIT_PROD, WR_LO, WR_HI, DONE, with state, op, set_flags, indices and accumulators registered on start in IDLE.
REQ-004 SHALL ignore start outside IDLE and prod_valid outside WAIT_PROD.
REQ-005 In WAIT_PROD, on prod_valid, SHALL capture the result and go to WR_LO.
REQ-006 Short result SHALL be prod_lo + (MLA ? acc_lo : 0), modulo 2^32.
REQ-007 Long result SHALL be {prod_hi,prod_lo} + (UMLAL/SMLAL ? {acc_hi,acc_lo} : 0), modulo 2^64.
REQ-008 In WR_LO, SHALL drive wr_en=1, wr_idx=rd_lo_idx, wr_data=result[31:0], held stable until the cycle wr_ready=1.
REQ-009 On the WR_LO handshake, a short op SHALL go to DONE and a long op SHALL go to WR_HI.
REQ-010 In WR_HI, SHALL drive wr_en=1, wr_idx=rd_hi_idx, wr_data=result[63:32] until wr_ready, then go to DONE.
REQ-011 For a long op with rd_lo_idx==rd_hi_idx, SHALL skip WR_LO and write only the high word.
REQ-012 DONE SHALL last exactly one cycle: done=1, flag_we=set_flags, err=0, then return to IDLE.
REQ-013 flag_n SHALL be result bit 31 (short) or bit 63 (long).
REQ-014 flag_z SHALL be 1 iff the full-width result is zero.
REQ-015 flag_n and flag_z SHALL be held until the next DONE.
REQ-016 SHALL count WAIT_PROD cycles; with no prod_valid after TIMEOUT_CYCLES cycles, SHALL go to DONE with err=1, flag_we=0 and no write.
REQ-017 An illegal op at start SHALL go directly to DONE with err=1, flag_we=0 and no write.
REQ-018 Minimum latency, with wr_ready tied high: start at cycle 0, prod_valid at cycle k gives wr_en at k+1 and done at k+2 (short) or k+3 (long).

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE and clear the timeout counter.
REQ-020 reset_n low SHALL force busy, wr_en, flag_we, done, err, flag_n and flag_z to 0, and wr_idx and wr_data to 0.
REQ-021 Reset mid-operation SHALL abandon the op without completing any pending write.

Configuration
REQ-022 Macro MUL_LONG_OPS_EN defined: ops 2-5 SHALL be supported as specified above.
REQ-023 Macro MUL_LONG_OPS_EN undefined: ops 2-5 SHALL be treated as illegal per REQ-017, WR_HI and the 64-bit datapath SHALL be absent, and short-op behaviour SHALL be unchanged.

Verification
REQ-024 MLA: acc_lo=5, prod_lo=0xFFFFFFFB, S=1 -> single write of 0x00000000 to rd_lo_idx, flag_z=1, flag_n=0, done one cycle after the write.
REQ-025 SMLAL: product 0xFFFFFFFF_FFFFFFFE, acc 0x00000000_00000001, rd_lo=2, rd_hi=3 -> R2<=0xFFFFFFFF then R3<=0xFFFFFFFF, flag_n=1, flag_z=0.
REQ-026 MUL with wr_ready low for 3 cycles -> wr_en, wr_idx and wr_data stable for 4 cycles, exactly one handshake.
REQ-027 start then no prod_valid for 8 cycles -> done=1 and err=1, wr_en never asserted, flag_we=0; a later prod_valid is ignored.
REQ-028 UMULL with rd_lo=rd_hi=4 -> one write, R4<=high word; reset_n pulsed during WAIT_PROD -> IDLE, busy=0, no write.
